// File: rtl/mem_log_multi_if.sv
// Host/stream bundle for mem_log_multi: capture inputs, control strobes and readback.
// The master side drives samples and commands; the slave side is the logger.
interface mem_log_multi_if #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 15,
   parameter int OUT_WIDTH  = 32
);
   localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic [NUM_CH*DATA_WIDTH-1:0] i_data;
   logic                         i_valid;
   logic                         i_run_log;
   logic                         i_stop_log;
   logic                         i_read_log;
   logic                         i_mode;
   logic [7:0]                   i_decim;
   logic [CH_W-1:0]              i_ch_sel;
   logic [ADDR_WIDTH-1:0]        i_addr_log_to_mem;
   logic                         o_mem_full;
   logic                         o_busy;
   logic                         o_wrapped;
   logic [OUT_WIDTH-1:0]         o_data_log_from_mem;

   modport master (
      output i_data, i_valid, i_run_log, i_stop_log, i_read_log,
             i_mode, i_decim, i_ch_sel, i_addr_log_to_mem,
      input  o_mem_full, o_busy, o_wrapped, o_data_log_from_mem
   );

   modport slave (
      input  i_data, i_valid, i_run_log, i_stop_log, i_read_log,
             i_mode, i_decim, i_ch_sel, i_addr_log_to_mem,
      output o_mem_full, o_busy, o_wrapped, o_data_log_from_mem
   );
endinterface

// File: rtl/mem_log_multi.sv
// Multi-channel BRAM sample logger: lock-step capture of NUM_CH channels with decimation,
// one-shot or circular (pre-trigger) mode, and per-word host readback.
module mem_log_multi #(
   parameter int NUM_CH     = 2,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 15,
   parameter int OUT_WIDTH  = 32
) (
   input  logic            clk,
   input  logic            i_rst_n,
   mem_log_multi_if.slave  bus
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FULL, S_READ} state_t;

   state_t                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
   logic [7:0]             decim_cnt_q, decim_cnt_d;
   logic [7:0]             decim_q, decim_d;
   logic                   mode_q, mode_d;
   logic                   wrapped_q, wrapped_d;
   logic                   rd_en_q;
   logic [CH_W-1:0]        ch_sel_q;

   logic                   start;
   logic                   wr_en;
   logic                   busy;
   logic                   mem_full;
   logic [ADDR_WIDTH-1:0]  rd_addr;
   logic [DATA_WIDTH-1:0]  rd_word [NUM_CH];
   logic [DATA_WIDTH-1:0]  sel_word;

   assign start = bus.i_run_log && (state_q != S_RUN);
   assign wr_en = (state_q == S_RUN) && bus.i_valid && (decim_cnt_q == 8'd0);

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN: begin
            if (mode_q ? bus.i_stop_log : (wr_en && (wr_ptr_q == LAST_ADDR))) begin
               state_d = S_FULL;
            end
         end
         S_FULL: begin
            // A simultaneous run request takes priority over readback.
            if (bus.i_run_log) begin
               state_d = S_RUN;
            end else if (bus.i_read_log) begin
               state_d = S_READ;
            end
         end
         default: begin
            if (bus.i_run_log) begin
               state_d = S_RUN;
            end
         end
      endcase
   end

   always_comb begin
      busy     = (state_q == S_RUN);
      mem_full = (state_q == S_FULL) || (state_q == S_READ);
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      decim_cnt_d = decim_cnt_q;
      decim_d     = decim_q;
      mode_d      = mode_q;
      wrapped_d   = wrapped_q;
      if (start) begin
         wr_ptr_d    = '0;
         decim_cnt_d = '0;
         wrapped_d   = 1'b0;
         mode_d      = bus.i_mode;
         decim_d     = bus.i_decim;
      end else if ((state_q == S_RUN) && bus.i_valid) begin
         decim_cnt_d = (decim_cnt_q == decim_q) ? 8'd0 : decim_cnt_q + 8'd1;
         if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (mode_q && (wr_ptr_q == LAST_ADDR)) begin
               wrapped_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         wr_ptr_q    <= '0;
         decim_cnt_q <= '0;
         decim_q     <= '0;
         mode_q      <= 1'b0;
         wrapped_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         decim_cnt_q <= decim_cnt_d;
         decim_q     <= decim_d;
         mode_q      <= mode_d;
         wrapped_q   <= wrapped_d;
      end
   end

   // Once wrapped, the write pointer marks the oldest surviving sample.
   assign rd_addr = (wrapped_q ? wr_ptr_q : '0) + bus.i_addr_log_to_mem;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] mem [DEPTH];
      logic [DATA_WIDTH-1:0] rd_q;

      always_ff @(posedge clk) begin
         if (wr_en) begin
            mem[wr_ptr_q] <= bus.i_data[gi*DATA_WIDTH +: DATA_WIDTH];
         end
         rd_q <= mem[rd_addr];
      end

      assign rd_word[gi] = rd_q;
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         rd_en_q  <= 1'b0;
         ch_sel_q <= '0;
      end else begin
         rd_en_q  <= mem_full;
         ch_sel_q <= bus.i_ch_sel;
      end
   end

   always_comb begin
      sel_word = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (int'(ch_sel_q) == k) begin
            sel_word = rd_word[k];
         end
      end
   end

   // Gating on the live state keeps the output at zero from the first RUN/IDLE cycle.
   assign bus.o_data_log_from_mem = (mem_full && rd_en_q) ? OUT_WIDTH'($signed(sel_word)) : '0;
   assign bus.o_busy              = busy;
   assign bus.o_mem_full          = mem_full;
   assign bus.o_wrapped           = wrapped_q;
endmodule

// File: tb/tb_mem_log_multi.sv
// Directed bench for mem_log_multi (2 channels, 16-deep) with a queue-based capture model
// checked every cycle, plus literal expectations pinning the model.
module tb_mem_log_multi;
   localparam int NUM_CH = 2;
   localparam int DW     = 16;
   localparam int AW     = 4;
   localparam int OW     = 32;
   localparam int DEPTH  = 2 ** AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_log_multi_if #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) bus ();

   mem_log_multi #(.NUM_CH(NUM_CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_WIDTH(OW)) dut (
      .clk     (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: what was kept, in order, and which phase the logger is in.
   typedef enum {P_IDLE, P_RUN, P_FULL, P_READ} phase_t;
   phase_t      ph = P_IDLE;
   logic [31:0] kept[$];
   int          n_valid = 0;
   int          m_decim = 0;
   bit          m_circ = 1'b0;
   bit          m_wrapped = 1'b0;
   bit          exp_dvalid = 1'b0;
   bit          exp_dknown = 1'b0;
   logic [31:0] exp_data = '0;

   function automatic bit readback(input int ch, input int a, output logic [31:0] v);
      int idx;
      logic [15:0] s;
      v = '0;
      idx = m_wrapped ? (kept.size() - DEPTH + a) : a;
      if (idx >= kept.size()) return 1'b0;
      s = (ch == 0) ? kept[idx][15:0] : kept[idx][31:16];
      v = {{16{s[15]}}, s};
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      phase_t prev;
      prev = ph;
      if (!rst_n) begin
         ph = P_IDLE;
         kept.delete();
         n_valid = 0;
         m_circ = 1'b0;
         m_wrapped = 1'b0;
         exp_dvalid = 1'b0;
      end else begin
         exp_dknown = readback(int'(bus.i_ch_sel), int'(bus.i_addr_log_to_mem), exp_data);
         if (bus.i_run_log && prev != P_RUN) begin
            ph = P_RUN;
            kept.delete();
            n_valid = 0;
            m_decim = int'(bus.i_decim);
            m_circ = bus.i_mode;
            m_wrapped = 1'b0;
         end else if (prev == P_RUN) begin
            if (bus.i_valid) begin
               if (n_valid % (m_decim + 1) == 0) begin
                  kept.push_back(bus.i_data);
                  if (m_circ && kept.size() >= DEPTH) m_wrapped = 1'b1;
               end
               n_valid++;
            end
            if (!m_circ && kept.size() == DEPTH) ph = P_FULL;
            else if (m_circ && bus.i_stop_log) ph = P_FULL;
         end else if (prev == P_FULL && bus.i_read_log) begin
            ph = P_READ;
         end
         exp_dvalid = (prev == P_FULL || prev == P_READ) && (ph == P_FULL || ph == P_READ);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(bus.o_busy), 32'(ph == P_RUN));
         chk("mem_full", 32'(bus.o_mem_full), 32'(ph == P_FULL || ph == P_READ));
         chk("wrapped", 32'(bus.o_wrapped), 32'(m_wrapped));
         if (ph == P_IDLE || ph == P_RUN) begin
            chk("data_zero", bus.o_data_log_from_mem, 32'h0);
         end else if (exp_dvalid && exp_dknown) begin
            chk("readback", bus.o_data_log_from_mem, exp_data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input logic [15:0] a, input logic [15:0] b);
      bus.i_data  = {b, a};
      bus.i_valid = 1'b1;
      tick();
      bus.i_valid = 1'b0;
   endtask

   task automatic start_run(input bit circ, input logic [7:0] dec);
      bus.i_mode    = circ;
      bus.i_decim   = dec;
      bus.i_run_log = 1'b1;
      tick();
      bus.i_run_log = 1'b0;
   endtask

   task automatic read_at(input int ch, input int a);
      logic [31:0] c, ad;
      c  = ch;
      ad = a;
      bus.i_ch_sel          = c[0];
      bus.i_addr_log_to_mem = ad[AW-1:0];
      tick();
      $display("[TB] read ch=%0d addr=%0d data=%h", ch, a, bus.o_data_log_from_mem);
   endtask

   task automatic sweep();
      for (int c = 0; c < NUM_CH; c++)
         for (int a = 0; a < DEPTH; a++) read_at(c, a);
   endtask

   initial begin
      bus.i_data = '0;  bus.i_valid = 1'b0; bus.i_run_log = 1'b0; bus.i_stop_log = 1'b0;
      bus.i_read_log = 1'b0; bus.i_mode = 1'b0; bus.i_decim = '0; bus.i_ch_sel = '0;
      bus.i_addr_log_to_mem = '0;
      repeat (3) tick();
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_busy", 32'(bus.o_busy), 32'h0);
      chk("reset_full", 32'(bus.o_mem_full), 32'h0);
      chk("reset_data", bus.o_data_log_from_mem, 32'h0);

      // One-shot, no decimation
      start_run(1'b0, 8'd0);
      for (int i = 0; i < 16; i++) begin
         sample(16'(i), 16'(16'h8000 + i));
         if (i == 14) chk("oneshot_not_full_early", 32'(bus.o_mem_full), 32'h0);
      end
      chk("oneshot_full_after_16", 32'(bus.o_mem_full), 32'h1);
      read_at(1, 3);
      chk("oneshot_ch1_addr3", bus.o_data_log_from_mem, 32'hFFFF8003);
      bus.i_read_log = 1'b1;
      tick();
      bus.i_read_log = 1'b0;
      sweep();

      // Gapped valid: same contents expected
      start_run(1'b0, 8'd0);
      for (int i = 0; i < 16; i++) begin
         sample(16'(i), 16'(16'h8000 + i));
         tick();
         tick();
      end
      read_at(1, 3);
      chk("gapped_ch1_addr3", bus.o_data_log_from_mem, 32'hFFFF8003);
      read_at(0, 9);
      chk("gapped_ch0_addr9", bus.o_data_log_from_mem, 32'h9);
      sweep();

      // Decimation by 3
      start_run(1'b0, 8'd2);
      for (int n = 0; n < 48; n++) begin
         sample(16'(n), 16'(n));
         if (n == 44) chk("decim_not_full_at_44", 32'(bus.o_mem_full), 32'h0);
         if (n == 45) chk("decim_full_at_45", 32'(bus.o_mem_full), 32'h1);
      end
      read_at(0, 5);
      chk("decim_addr5", bus.o_data_log_from_mem, 32'd15);
      read_at(0, 15);
      chk("decim_addr15", bus.o_data_log_from_mem, 32'd45);
      sweep();

      // Run and read together in FULL: run wins, then circular capture
      bus.i_mode = 1'b1;
      bus.i_decim = 8'd0;
      bus.i_run_log = 1'b1;
      bus.i_read_log = 1'b1;
      tick();
      bus.i_run_log = 1'b0;
      bus.i_read_log = 1'b0;
      chk("run_wins_busy", 32'(bus.o_busy), 32'h1);
      chk("run_wins_not_full", 32'(bus.o_mem_full), 32'h0);
      for (int i = 0; i < 20; i++) sample(16'(i), 16'(16'h8000 + i));
      bus.i_stop_log = 1'b1;
      tick();
      bus.i_stop_log = 1'b0;
      chk("circ_wrapped", 32'(bus.o_wrapped), 32'h1);
      chk("circ_full", 32'(bus.o_mem_full), 32'h1);
      read_at(0, 0);
      chk("circ_addr0", bus.o_data_log_from_mem, 32'd4);
      read_at(0, 15);
      chk("circ_addr15", bus.o_data_log_from_mem, 32'd19);
      sweep();

      // Circular stop coinciding with a sample write
      start_run(1'b1, 8'd0);
      sample(16'hA0, 16'hB0);
      sample(16'hA1, 16'hB1);
      bus.i_data = {16'hB2, 16'hA2};
      bus.i_valid = 1'b1;
      bus.i_stop_log = 1'b1;
      tick();
      bus.i_valid = 1'b0;
      bus.i_stop_log = 1'b0;
      chk("stop_write_full", 32'(bus.o_mem_full), 32'h1);
      chk("stop_write_not_wrapped", 32'(bus.o_wrapped), 32'h0);
      read_at(0, 2);
      chk("stop_write_addr2", bus.o_data_log_from_mem, 32'h0000_00A2);

      // Reset mid-run after a wrap
      start_run(1'b1, 8'd0);
      for (int i = 0; i < 18; i++) sample(16'(i + 50), 16'(i));
      rst_n = 1'b0;
      tick();
      chk("rst_busy", 32'(bus.o_busy), 32'h0);
      chk("rst_full", 32'(bus.o_mem_full), 32'h0);
      chk("rst_wrapped", 32'(bus.o_wrapped), 32'h0);
      chk("rst_data", bus.o_data_log_from_mem, 32'h0);
      rst_n = 1'b1;
      tick();
      start_run(1'b0, 8'd0);
      for (int i = 0; i < 16; i++) sample(16'(100 + i), 16'(16'hFF00 + i));
      read_at(0, 0);
      chk("after_rst_addr0", bus.o_data_log_from_mem, 32'd100);
      read_at(1, 15);
      chk("after_rst_ch1_addr15", bus.o_data_log_from_mem, 32'hFFFF_FF0F);

      tick();
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
